// File: rtl/huffman_dc_decoder.sv
// Bit-serial JPEG DC Huffman decoder: consumes category code + magnitude bits one per
// handshake and emits the category with its sign-extended DC difference.
module huffman_dc_decoder #(
  parameter int DIFF_W  = 12,
  parameter int MAX_CAT = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_luminance,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic [3:0]        dc_size,
  output logic [DIFF_W-1:0] dc_diff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  localparam int CODE_W = 11;
  localparam int MAG_W  = MAX_CAT;

  typedef enum logic [1:0] {S_CODE, S_MAG, S_OUT, S_ERR} state_e;

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  code_reg_q, code_reg_d;
  logic [3:0]         code_len_q, code_len_d;
  logic               luma_q, luma_d;
  logic [3:0]         size_q, size_d;
  logic [3:0]         mag_cnt_q, mag_cnt_d;
  logic [MAG_W-1:0]   mag_reg_q, mag_reg_d;
  logic [3:0]         dc_size_q, dc_size_d;
  logic [DIFF_W-1:0]  dc_diff_q, dc_diff_d;
  logic               out_valid_q, out_valid_d;
  logic               bit_ready_q, bit_ready_d;
  logic               err_q, err_d;

  // Returns {hit, category}. Only the low len bits of code take part in the compare.
  function automatic logic [4:0] lookup(input logic luma, input logic [3:0] len,
                                        input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] masked;
    logic [CODE_W-1:0] ones_zero;
    logic [4:0]        res;
    masked    = code & ((CODE_W'(1) << len) - CODE_W'(1));
    ones_zero = (CODE_W'(1) << len) - CODE_W'(2);
    res       = 5'd0;
    if (luma) begin
      if (len == 4'd2 && masked == '0)
        res = {1'b1, 4'd0};
      else if (len == 4'd3 && masked >= CODE_W'(2) && masked <= CODE_W'(6))
        res = {1'b1, masked[3:0] - 4'd1};
      else if (len >= 4'd4 && len <= 4'd9 && masked == ones_zero)
        res = {1'b1, len + 4'd2};
    end else begin
      if (len == 4'd2 && masked <= CODE_W'(2))
        res = {1'b1, masked[3:0]};
      else if (len >= 4'd3 && len <= 4'd11 && masked == ones_zero)
        res = {1'b1, len};
    end
    return res;
  endfunction

  always_comb begin
    logic              sel_luma;
    logic [CODE_W-1:0] code_new;
    logic [3:0]        len_new;
    logic [4:0]        hit_cat;
    logic [MAG_W-1:0]  mag_new;
    logic [3:0]        cnt_new;
    logic [DIFF_W-1:0] mag_ext;
    // NOTE: every _d gets a default first so no path through this block can infer a latch;
    // intermediates use blocking '=' here, state updates use '<=' in the always_ff.
    state_d     = state_q;
    code_reg_d  = code_reg_q;
    code_len_d  = code_len_q;
    luma_d      = luma_q;
    size_d      = size_q;
    mag_cnt_d   = mag_cnt_q;
    mag_reg_d   = mag_reg_q;
    dc_size_d   = dc_size_q;
    dc_diff_d   = dc_diff_q;
    out_valid_d = out_valid_q;
    bit_ready_d = bit_ready_q;
    err_d       = err_q;
    sel_luma    = (code_len_q == 4'd0) ? is_luminance : luma_q;
    code_new    = {code_reg_q[CODE_W-2:0], bit_in};
    len_new     = code_len_q + 4'd1;
    hit_cat     = lookup(sel_luma, len_new, code_new);
    mag_new     = {mag_reg_q[MAG_W-2:0], bit_in};
    cnt_new     = mag_cnt_q + 4'd1;
    mag_ext     = DIFF_W'(mag_new);

    case (state_q)
      S_CODE: if (bit_valid && bit_ready_q) begin
        code_reg_d = code_new;
        code_len_d = len_new;
        if (code_len_q == 4'd0) luma_d = is_luminance;
        if (hit_cat[4]) begin
          if (hit_cat[3:0] == 4'd0) begin
            dc_size_d   = 4'd0;
            dc_diff_d   = '0;
            out_valid_d = 1'b1;
            bit_ready_d = 1'b0;
            state_d     = S_OUT;
          end else begin
            size_d    = hit_cat[3:0];
            mag_cnt_d = 4'd0;
            mag_reg_d = '0;
            state_d   = S_MAG;
          end
        end else if (len_new == (sel_luma ? 4'd9 : 4'd11)) begin
          err_d       = 1'b1;
          bit_ready_d = 1'b0;
          state_d     = S_ERR;
        end
      end
      S_MAG: if (bit_valid && bit_ready_q) begin
        mag_reg_d = mag_new;
        mag_cnt_d = cnt_new;
        if (cnt_new == size_q) begin
          dc_size_d = size_q;
          // A leading 0 marks a negative value stored as its ones' complement.
          if (mag_new[size_q - 4'd1])
            dc_diff_d = mag_ext;
          else
            dc_diff_d = mag_ext - ((DIFF_W'(1) << size_q) - DIFF_W'(1));
          out_valid_d = 1'b1;
          bit_ready_d = 1'b0;
          state_d     = S_OUT;
        end
      end
      S_OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        code_reg_d  = '0;
        code_len_d  = 4'd0;
        bit_ready_d = 1'b1;
        state_d     = S_CODE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CODE;
      code_reg_q  <= '0;
      code_len_q  <= 4'd0;
      luma_q      <= 1'b0;
      size_q      <= 4'd0;
      mag_cnt_q   <= 4'd0;
      mag_reg_q   <= '0;
      dc_size_q   <= 4'd0;
      dc_diff_q   <= '0;
      out_valid_q <= 1'b0;
      bit_ready_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_reg_q  <= code_reg_d;
      code_len_q  <= code_len_d;
      luma_q      <= luma_d;
      size_q      <= size_d;
      mag_cnt_q   <= mag_cnt_d;
      mag_reg_q   <= mag_reg_d;
      dc_size_q   <= dc_size_d;
      dc_diff_q   <= dc_diff_d;
      out_valid_q <= out_valid_d;
      bit_ready_q <= bit_ready_d;
      err_q       <= err_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign dc_size   = dc_size_q;
  assign dc_diff   = dc_diff_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_huffman_dc_decoder.sv
// Directed bench for huffman_dc_decoder: hand-computed symbols, backpressure, error and reset.
module tb_huffman_dc_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_luminance;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [3:0]  dc_size;
  logic [11:0] dc_diff;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  huffman_dc_decoder #(.DIFF_W(12), .MAX_CAT(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .is_luminance (is_luminance),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .dc_size      (dc_size),
    .dc_diff      (dc_diff),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one bit for one cycle; bit_ready must already be high.
  task automatic send_bit(input logic b);
    check("bit_ready_before_send", 32'(bit_ready), 32'd1);
    bit_in    = b;
    bit_valid = 1'b1;
    tick(1);
    bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  // Result must be present right after the last bit; out_ready is assumed high.
  task automatic expect_result(input string tag, input logic [3:0] sz, input logic [11:0] diff);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_size"}, 32'(dc_size), 32'(sz));
    check({tag, "_diff"}, 32'(dc_diff), 32'(diff));
    check({tag, "_ready_low"}, 32'(bit_ready), 32'd0);
    tick(1);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; is_luminance = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b1;
    tick(2);
    check("rst_bit_ready", 32'(bit_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dc_size", 32'(dc_size), 32'd0);
    check("rst_dc_diff", 32'(dc_diff), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(1);

    // T1: luma cat0
    send_bits(32'b00, 2);
    expect_result("t1", 4'd0, 12'h000);

    // T2: luma cat2 positive and negative
    send_bits(32'b011_10, 5);
    expect_result("t2_pos", 4'd2, 12'h002);
    send_bits(32'b011_01, 5);
    expect_result("t2_neg", 4'd2, 12'hFFE);

    // T3: chroma cat1, table select flipped after first bit must be ignored
    is_luminance = 1'b0;
    send_bit(1'b0);
    is_luminance = 1'b1;
    send_bits(32'b1_0, 2);
    expect_result("t3_chroma", 4'd1, 12'hFFF);
    send_bits(32'b111111110, 9);
    send_bits(32'h7FF, 11);
    expect_result("t3_cat11", 4'd11, 12'h7FF);

    // T4: backpressure with gaps between bits, then a follow-up symbol
    out_ready = 1'b0;
    send_bit(1'b0);
    tick(2);
    send_bits(32'b10, 2);
    tick(1);
    send_bit(1'b1);
    check("t4_valid", 32'(out_valid), 32'd1);
    bit_in = 1'b0; bit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t4_hold_valid", 32'(out_valid), 32'd1);
      check("t4_hold_ready", 32'(bit_ready), 32'd0);
      check("t4_hold_size", 32'(dc_size), 32'd1);
      check("t4_hold_diff", 32'(dc_diff), 32'h001);
    end
    bit_valid = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("t4_release", 32'(out_valid), 32'd0);
    send_bits(32'b101_0110, 7);
    expect_result("t4_next", 4'd4, 12'hFF7);

    // T5: invalid luma code, sticky error, recovery by reset
    send_bits(32'b111111111, 9);
    check("t5_err", 32'(err), 32'd1);
    check("t5_ready", 32'(bit_ready), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    bit_in = 1'b0; bit_valid = 1'b1;
    tick(3);
    bit_valid = 1'b0;
    check("t5_err_sticky", 32'(err), 32'd1);
    check("t5_ready_held", 32'(bit_ready), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_err_cleared", 32'(err), 32'd0);
    check("t5_ready_back", 32'(bit_ready), 32'd1);
    send_bits(32'b00, 2);
    expect_result("t5_after", 4'd0, 12'h000);

    // T6: reset in the middle of a cat5 magnitude discards the symbol
    send_bits(32'b110_11, 5);
    check("t6_mid_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    check("t6_no_valid", 32'(out_valid), 32'd0);
    check("t6_ready", 32'(bit_ready), 32'd1);
    send_bits(32'b100_111, 6);
    expect_result("t6_next", 4'd3, 12'h007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
